// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the 16x8 data memory and its block-transfer engine.
// Provides the address/data/depth widths, the command mode and engine state
// enumerations, and a helper that clamps a requested byte count to the
// memory depth.
package dmem_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LEN_W  = 5;

    typedef enum logic [1:0] {
        COPY    = 2'd0,
        FILL    = 2'd1,
        COMPARE = 2'd2,
        NOP     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A block can never be longer than the memory itself, so anything larger
    // is treated as a full-memory operation.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    endfunction

endpackage

// File: rtl/dmem_dma_if.sv
// dmem_dma_if
// Bundles the command handshake and the data-memory port signals of the
// block-transfer engine.
//   cmd_valid/cmd_ready       command handshake
//   cmd_mode/src/dst/len/fill command fields
//   mem_we/waddr/wdata        memory write port
//   mem_raddr1/raddr2         memory read addresses
//   mem_rdata1/rdata2         combinational read data
// Modports:
//   master - the engine: takes commands, initiates memory accesses
//   slave  - the environment: issues commands, hosts the memory
interface dmem_dma_if;
    import dmem_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_mode;
    logic [ADDR_W-1:0]     cmd_src;
    logic [ADDR_W-1:0]     cmd_dst;
    logic [LEN_W-1:0]      cmd_len;
    logic [DATA_W-1:0]     cmd_fill;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [ADDR_W-1:0]     mem_raddr1;
    logic [ADDR_W-1:0]     mem_raddr2;
    logic [DATA_W-1:0]     mem_rdata1;
    logic [DATA_W-1:0]     mem_rdata2;

    modport master (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        input  mem_rdata1, mem_rdata2,
        output cmd_ready,
        output mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2
    );

    modport slave (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        output mem_rdata1, mem_rdata2,
        input  cmd_ready,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2
    );

endinterface

// File: rtl/dmem_dma.sv
// dmem_dma
// Command-driven block engine for the 16x8 data memory. Accepts one COPY,
// FILL or COMPARE command at a time and moves or checks one byte per cycle,
// finishing with a one-cycle done pulse.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           dmem_dma_if.master: command handshake + memory ports
//   busy          command in progress (RUN or DONE)
//   done          one-cycle completion pulse
//   mismatch      COMPARE found a difference
//   mismatch_idx  offset of the first differing byte
//   checksum      mod-256 sum of bytes moved/read (only with
//                 DMEM_DMA_CHECKSUM_EN defined)
module dmem_dma
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dmem_dma_if.master        bus,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [ADDR_W-1:0] mismatch_idx
`ifdef DMEM_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_e            state;
    mode_e             mode_q;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [DATA_W-1:0] fill_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              mismatch_q;
    logic [ADDR_W-1:0] mismatch_idx_q;
`ifdef DMEM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
`endif

    logic              run;
    logic              we_int;
    logic [DATA_W-1:0] wdata_int;
    logic [LEN_W-1:0]  acc_len;
    mode_e             acc_mode;

    assign acc_len  = sat_len(bus.cmd_len);
    assign acc_mode = mode_e'(bus.cmd_mode);

    // Memory port decode. Pointers advance every RUN cycle, so the current
    // byte's addresses are simply the pointer registers. COPY data comes
    // straight from read port 1, which lets a byte written this cycle be
    // read back by the next cycle when the regions overlap.
    assign run       = (state == RUN);
    assign we_int    = run && (mode_q == COPY || mode_q == FILL);
    assign wdata_int = (mode_q == COPY) ? bus.mem_rdata1 : fill_q;

    // The write enable is masked by reset directly so a reset arriving
    // mid-block can never commit the in-flight byte.
    assign bus.mem_we     = we_int && !reset;
    assign bus.mem_wdata  = (we_int && !reset) ? wdata_int : '0;
    assign bus.mem_waddr  = we_int ? dst_ptr : '0;
    assign bus.mem_raddr1 = (run && (mode_q == COPY || mode_q == COMPARE)) ? src_ptr : '0;
    assign bus.mem_raddr2 = (run && mode_q == COMPARE) ? dst_ptr : '0;

    assign bus.cmd_ready  = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch       = mismatch_q;
    assign mismatch_idx   = mismatch_idx_q;
`ifdef DMEM_DMA_CHECKSUM_EN
    assign checksum       = checksum_q;
`endif

    // Engine FSM. Empty and reserved-mode commands skip RUN entirely and go
    // straight to the done pulse. Result registers are only cleared on the
    // next accept so software can read them any time after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mode_q         <= COPY;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            fill_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
`ifdef DMEM_DMA_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.cmd_valid && ready_q) begin
                        mode_q         <= acc_mode;
                        src_ptr        <= bus.cmd_src;
                        dst_ptr        <= bus.cmd_dst;
                        fill_q         <= bus.cmd_fill;
                        len_q          <= acc_len;
                        idx_q          <= '0;
                        ready_q        <= 1'b0;
                        busy_q         <= 1'b1;
                        mismatch_q     <= 1'b0;
                        mismatch_idx_q <= '0;
`ifdef DMEM_DMA_CHECKSUM_EN
                        checksum_q     <= '0;
`endif
                        if (acc_len == '0 || acc_mode == NOP) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end

                RUN: begin
                    idx_q   <= idx_q + LEN_W'(1);
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    // Only the first difference is recorded; the block still
                    // runs to its full length.
                    if (mode_q == COMPARE && !mismatch_q &&
                        bus.mem_rdata1 != bus.mem_rdata2) begin
                        mismatch_q     <= 1'b1;
                        mismatch_idx_q <= idx_q[ADDR_W-1:0];
                    end
`ifdef DMEM_DMA_CHECKSUM_EN
                    checksum_q <= checksum_q +
                                  ((mode_q == COMPARE) ? bus.mem_rdata1 : wdata_int);
`endif
                    if (idx_q + LEN_W'(1) == len_q) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma
// Self-checking bench for dmem_dma. Hosts a 16x8 memory on the slave side
// of dmem_dma_if, keeps an independent byte-level model of every command,
// and compares the engine's outputs against that model on every cycle.
// Optional checksum checks follow DMEM_DMA_CHECKSUM_EN.
module tb_dmem_dma;
    import dmem_pkg::*;

    typedef struct {
        logic       ready;
        logic       busy;
        logic       done;
        logic       we;
        logic [3:0] waddr;
        logic [3:0] raddr1;
        logic [3:0] raddr2;
        logic [7:0] wdata;
        bit         care_addr;
        bit         care_status;
        bit         is_reset;
        logic       mm;
        logic [3:0] mmi;
        logic [7:0] cks;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [3:0] mismatch_idx;
`ifdef DMEM_DMA_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    dmem_dma_if bus();

    dmem_dma dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
`ifdef DMEM_DMA_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Bench-hosted data memory with a backdoor write port for preloading.
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic       bd_we = 1'b0;
    logic [3:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    assign bus.mem_rdata1 = mem[bus.mem_raddr1];
    assign bus.mem_rdata2 = mem[bus.mem_raddr2];

    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_waddr] <= bus.mem_wdata;
        else if (bd_we)
            mem[bd_addr] <= bd_data;
    end

    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;
    exp_t exp_q[$];
    logic       held_mm = 1'b0;
    logic [3:0] held_mmi = '0;
    logic [7:0] held_cks = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t idleRec();
        exp_t r;
        r = '{default: 0};
        r.ready       = 1'b1;
        r.care_addr   = 1'b1;
        r.care_status = 1'b1;
        r.mm          = held_mm;
        r.mmi         = held_mmi;
        r.cks         = held_cks;
        return r;
    endfunction

    // Per-cycle comparison against the model's expected cycle records.
    initial begin : compare_proc
        exp_t r;
        forever begin
            @(negedge clk);
            if (check_en) begin
                if (exp_q.size() > 0) r = exp_q.pop_front();
                else                  r = idleRec();
                if (r.is_reset) begin
                    checkOutput("reset_cycle_we", 32'(bus.mem_we), 32'(0));
                    checkOutput("reset_cycle_wdata", 32'(bus.mem_wdata), 32'(0));
                    checkOutput("reset_cycle_done", 32'(done), 32'(0));
                    held_mm  = 1'b0;
                    held_mmi = '0;
                    held_cks = '0;
                end else begin
                    checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(r.ready));
                    checkOutput("busy", 32'(busy), 32'(r.busy));
                    checkOutput("done", 32'(done), 32'(r.done));
                    checkOutput("mem_we", 32'(bus.mem_we), 32'(r.we));
                    checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(r.wdata));
                    if (r.care_addr) begin
                        checkOutput("mem_waddr", 32'(bus.mem_waddr), 32'(r.waddr));
                        checkOutput("mem_raddr1", 32'(bus.mem_raddr1), 32'(r.raddr1));
                        checkOutput("mem_raddr2", 32'(bus.mem_raddr2), 32'(r.raddr2));
                    end
                    if (r.care_status) begin
                        checkOutput("mismatch", 32'(mismatch), 32'(r.mm));
                        checkOutput("mismatch_idx", 32'(mismatch_idx), 32'(r.mmi));
`ifdef DMEM_DMA_CHECKSUM_EN
                        checkOutput("checksum", 32'(checksum), 32'(r.cks));
`endif
                        held_mm  = r.mm;
                        held_mmi = r.mmi;
                        held_cks = r.cks;
                    end
                end
            end
        end
    end

    task automatic loadMem(input logic [3:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one command from an idle cycle start, builds the expected cycle
    // trace from the byte-level semantics, and waits for the trace to drain.
    // reset_at >= 0 asserts reset during the RUN cycle handling that offset.
    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] src,
                                 input logic [3:0] dst, input logic [4:0] len,
                                 input logic [7:0] fill, input int reset_at,
                                 output int lat);
        exp_t       tmp[$];
        exp_t       r;
        int         n;
        bit         aborted;
        logic       mm;
        logic [3:0] mmi;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] cks;

        n       = (len > 5'd16) ? 16 : int'(len);
        aborted = 1'b0;
        mm      = 1'b0;
        mmi     = '0;
        cks     = '0;
        if (mode != 2'd3) begin
            for (int k = 0; k < n; k++) begin
                a = src + 4'(k);
                b = dst + 4'(k);
                r = '{default: 0};
                r.busy      = 1'b1;
                r.care_addr = 1'b1;
                if (k == reset_at) begin
                    r.is_reset  = 1'b1;
                    r.care_addr = 1'b0;
                    tmp.push_back(r);
                    aborted = 1'b1;
                    break;
                end
                case (mode)
                    2'd0: begin
                        r.we     = 1'b1;
                        r.raddr1 = a;
                        r.waddr  = b;
                        r.wdata  = ref_mem[a];
                        ref_mem[b] = ref_mem[a];
                        cks += r.wdata;
                    end
                    2'd1: begin
                        r.we    = 1'b1;
                        r.waddr = b;
                        r.wdata = fill;
                        ref_mem[b] = fill;
                        cks += fill;
                    end
                    default: begin
                        r.raddr1 = a;
                        r.raddr2 = b;
                        if (!mm && ref_mem[a] != ref_mem[b]) begin
                            mm  = 1'b1;
                            mmi = 4'(k);
                        end
                        cks += ref_mem[a];
                    end
                endcase
                tmp.push_back(r);
            end
        end
        if (!aborted) begin
            r = '{default: 0};
            r.busy        = 1'b1;
            r.done        = 1'b1;
            r.care_addr   = 1'b1;
            r.care_status = 1'b1;
            r.mm          = mm;
            r.mmi         = mmi;
            r.cks         = cks;
            tmp.push_back(r);
        end

        bus.cmd_mode  = mode;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_len   = len;
        bus.cmd_fill  = fill;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        foreach (tmp[j]) exp_q.push_back(tmp[j]);

        lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (exp_q.size() == 0) break;
            if (done === 1'b1 && lat == 0) lat = cyc;
            reset = (cyc == reset_at + 1);
            if (exp_q.size() > 1) begin
                bus.cmd_valid = 1'($urandom);
                bus.cmd_mode  = 2'($urandom);
                bus.cmd_src   = 4'($urandom);
                bus.cmd_dst   = 4'($urandom);
                bus.cmd_len   = 5'($urandom);
                bus.cmd_fill  = 8'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL trace_timeout: actual %0d records left, required 0", exp_q.size());
            exp_q.delete();
        end
        for (int i = 0; i < 16; i++)
            checkOutput("mem_contents", 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stimulus
        int         lat;
        logic [7:0] v;
        logic [7:0] copy_exp [4];

        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = '0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.cmd_fill  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) loadMem(4'(i), 8'($urandom));

        // FILL dst=3 len=4
        $display("[TB] directed FILL");
        applyStimulus(2'd1, 4'd9, 4'd3, 5'd4, 8'hA5, -1, lat);
        checkOutput("fill_done_latency", 32'(lat), 32'd5);
        for (int i = 3; i <= 6; i++) checkOutput("fill_byte", 32'(mem[i]), 32'hA5);

        // COPY with wrap and overlap
        $display("[TB] directed COPY");
        loadMem(4'd14, 8'd1);
        loadMem(4'd15, 8'd2);
        loadMem(4'd0, 8'd3);
        loadMem(4'd1, 8'd4);
        applyStimulus(2'd0, 4'd14, 4'd0, 5'd4, 8'h00, -1, lat);
        copy_exp = '{8'd1, 8'd2, 8'd1, 8'd2};
        for (int i = 0; i < 4; i++) checkOutput("copy_byte", 32'(mem[i]), 32'(copy_exp[i]));

        // COMPARE with two differences
        $display("[TB] directed COMPARE");
        for (int k = 0; k < 8; k++) begin
            v = 8'($urandom);
            loadMem(4'(k), v);
            loadMem(4'(8 + k), v);
        end
        loadMem(4'd13, ref_mem[5] ^ 8'h5A);
        loadMem(4'd15, ref_mem[7] + 8'd1);
        applyStimulus(2'd2, 4'd0, 4'd8, 5'd8, 8'h00, -1, lat);
        checkOutput("cmp_mismatch", 32'(mismatch), 32'd1);
        checkOutput("cmp_mismatch_idx", 32'(mismatch_idx), 32'd5);

        // Degenerate commands and length saturation
        $display("[TB] directed len0 / NOP / len20");
        applyStimulus(2'd0, 4'd2, 4'd7, 5'd0, 8'h00, -1, lat);
        checkOutput("len0_done_latency", 32'(lat), 32'd1);
        applyStimulus(2'd3, 4'd2, 4'd7, 5'd7, 8'h00, -1, lat);
        checkOutput("nop_done_latency", 32'(lat), 32'd1);
        applyStimulus(2'd1, 4'd0, 4'd5, 5'd20, 8'h6E, -1, lat);
        checkOutput("len20_done_latency", 32'(lat), 32'd17);
        for (int i = 0; i < 16; i++) checkOutput("len20_byte", 32'(mem[i]), 32'h6E);

        // Reset in the middle of a FILL
        $display("[TB] directed reset mid-FILL");
        for (int k = 0; k < 8; k++) loadMem(4'(k), 8'h00);
        applyStimulus(2'd1, 4'd0, 4'd0, 5'd8, 8'h3C, 2, lat);
        checkOutput("rst_no_done", 32'(lat), 32'd0);
        checkOutput("rst_byte0", 32'(mem[0]), 32'h3C);
        checkOutput("rst_byte1", 32'(mem[1]), 32'h3C);
        checkOutput("rst_byte2", 32'(mem[2]), 32'h00);

`ifdef DMEM_DMA_CHECKSUM_EN
        $display("[TB] directed checksum");
        applyStimulus(2'd1, 4'd0, 4'd0, 5'd16, 8'h11, -1, lat);
        checkOutput("checksum_fill16", 32'(checksum), 32'h10);
`endif

        // Randomized commands
        $display("[TB] random commands");
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                          5'($urandom_range(0, 20)), 8'($urandom), -1, lat);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
